// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encodings for the pipeline controller.
package pipe_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MD_CNT_W = 4;

  localparam logic [XLEN-1:0]     EXC_VECTOR  = 32'h0000_4180;
  localparam logic [MD_CNT_W-1:0] MULT_CYCLES = 4'd5;
  localparam logic [MD_CNT_W-1:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy counter: loads the op latency on an accepted start and
// counts down to zero; busy while nonzero.
module md_busy_counter
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  // A start while already counting is dropped; the running op is never cut short.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - MD_CNT_W'(1);
    end else if (start) begin
      cnt_d = is_div ? DIV_CYCLES : MULT_CYCLES;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: stage enables, flushes, exception/eret
// redirect and mult/div interlock. Define PIPE_CTRL_PERF_EN for perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_req,
  input  logic            d_uses_md,
  input  logic            md_start,
  input  logic            md_is_div,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [XLEN-1:0] epc,
  output logic            pc_we,
  output logic            fd_we,
  output logic            de_we,
  output logic            em_we,
  output logic            mw_we,
  output logic            fd_flush,
  output logic            de_flush,
  output logic            em_flush,
  output logic            mw_flush,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            md_busy,
  output logic [XLEN-1:0] perf_stall_cnt,
  output logic [XLEN-1:0] perf_flush_cnt
);

  state_e state_q, state_d;
  logic   redirect;
  logic   stall;
  logic   md_hazard;
  logic   md_start_ok;

  assign md_hazard = d_uses_md & (md_busy | md_start);

  // Next state and pipeline controls; redirect outranks any stall.
  always_comb begin
    state_d     = state_q;
    redirect    = 1'b0;
    stall       = 1'b0;
    redirect_pc = '0;
    pc_we       = 1'b1;
    fd_we       = 1'b1;
    de_we       = 1'b1;
    em_we       = 1'b1;
    mw_we       = 1'b1;
    fd_flush    = 1'b0;
    de_flush    = 1'b0;
    em_flush    = 1'b0;
    mw_flush    = 1'b0;
    pc_redirect = 1'b0;

    if (!reset) begin
      unique case (state_q)
        ST_RUN: begin
          if (exc_req) begin
            redirect    = 1'b1;
            redirect_pc = EXC_VECTOR;
            state_d     = ST_HOLD;
          end else if (eret_req) begin
            redirect    = 1'b1;
            redirect_pc = epc;
            state_d     = ST_HOLD;
          end else begin
            stall = stall_req | md_hazard;
          end
        end
        ST_HOLD: begin
          stall   = md_hazard;
          state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end

    if (redirect) begin
      pc_redirect = 1'b1;
      fd_flush    = 1'b1;
      de_flush    = 1'b1;
      em_flush    = 1'b1;
    end else if (stall) begin
      pc_we    = 1'b0;
      fd_we    = 1'b0;
      de_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // The E-stage instruction is flushed on a redirect, so its issue is dropped.
  assign md_start_ok = md_start & ~redirect;

  md_busy_counter u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_ok),
    .is_div (md_is_div),
    .busy   (md_busy)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [XLEN-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall)       stall_cnt_q <= stall_cnt_q + XLEN'(1);
      if (pc_redirect) flush_cnt_q <= flush_cnt_q + XLEN'(1);
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
